// File: rtl/mem_request_sequencer.sv
// mem_request_sequencer
//   MEM-stage front end of the memory-access controller. Takes one load request
//   at a time from EX/MEM, holds ENABLE/CTRL/ADDRESS stable to the controller
//   until its HANDSHAKE, then hands the read word to MEM/WB with valid/ready.
//   STALL freezes the upstream stages for the whole transaction, and the
//   RECOVER state guarantees an ENABLE-low gap with HANDSHAKE seen low before
//   the next request is issued.
//
// Optional build macro:
//   MEM_TIMEOUT_EN - adds a WAIT watchdog (TIMEOUT_CYCLES, 10-bit) and an ABORT
//                    state that returns a zero word and sets a sticky ERROR.
//                    Without it WAIT waits indefinitely and ERROR is tied 0.
//
// Ports:
//   CLK, RESET            clock, async active-low reset
//   REQ_VALID/REQ_READY   request handshake from EX/MEM
//   REQ_CTRL, REQ_ADDR    request control (bit0 ROM select, [2:1] mode) / index
//   FLUSH                 pipeline flush, discards the in-flight result
//   MA_ENABLE/CTRL/ADDRESS  to memory-access controller
//   MA_READ, MA_HANDSHAKE   from memory-access controller
//   RSP_VALID/RSP_DATA/RSP_READY  response handshake to MEM/WB
//   STALL                 upstream freeze
//   ERROR                 sticky watchdog flag
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a request
// ISSUE    | first ENABLE cycle; a HANDSHAKE here is stale and ignored
// WAIT     | ENABLE held until HANDSHAKE
// RESP     | result presented to MEM/WB
// RECOVER  | ENABLE low until HANDSHAKE drops (at least one cycle)
// ABORT    | watchdog expired, zero response with ERROR (macro only)

module mem_request_sequencer #(
  parameter int DATA_W         = 48,
  parameter int ADDR_W         = 48,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_CTRL,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic              FLUSH,
  output logic              MA_ENABLE,
  output logic [2:0]        MA_CTRL,
  output logic [ADDR_W-1:0] MA_ADDRESS,
  input  logic [DATA_W-1:0] MA_READ,
  input  logic              MA_HANDSHAKE,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  input  logic              RSP_READY,
  output logic              STALL,
  output logic              ERROR
);

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_RECOVER, S_ABORT
  } state_t;
  // Down-counter loaded on WAIT entry; terminal count 0 marks the last WAIT cycle.
  localparam logic [9:0] WD_LOAD = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] wd_q, wd_d;
  logic       error_q, error_d;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_RECOVER
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                discard_q, discard_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      discard_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wd_q      <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      discard_q <= discard_d;
`ifdef MEM_TIMEOUT_EN
      wd_q      <= wd_d;
      error_q   <= error_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    data_d    = data_q;
    discard_d = discard_q;
`ifdef MEM_TIMEOUT_EN
    wd_d      = wd_q;
    error_d   = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          ctrl_d    = REQ_CTRL;
          addr_d    = REQ_ADDR;
          discard_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (FLUSH) discard_d = 1'b1;
        state_d = S_WAIT;
`ifdef MEM_TIMEOUT_EN
        wd_d = WD_LOAD;
`endif
      end
      S_WAIT: begin
        if (FLUSH) discard_d = 1'b1;
        if (MA_HANDSHAKE) begin
          data_d = MA_READ;
          // A flush arriving together with the handshake still discards.
          state_d = (discard_q || FLUSH) ? S_RECOVER : S_RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wd_q == '0) begin
          data_d  = '0;
          error_d = 1'b1;
          state_d = S_ABORT;
        end else begin
          wd_d = wd_q - 10'd1;
        end
`endif
      end
      S_RESP: begin
        if (FLUSH || RSP_READY) state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (!MA_HANDSHAKE) state_d = S_IDLE;
      end
`ifdef MEM_TIMEOUT_EN
      S_ABORT: begin
        if (FLUSH || RSP_READY) state_d = S_RECOVER;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register so reset drops ENABLE at once.
  assign REQ_READY  = (state_q == S_IDLE);
  assign MA_ENABLE  = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign MA_CTRL    = ctrl_q;
  assign MA_ADDRESS = addr_q;
  assign RSP_DATA   = data_q;
  assign STALL      = (state_q != S_IDLE) || REQ_VALID;

`ifdef MEM_TIMEOUT_EN
  assign RSP_VALID = (state_q == S_RESP) || (state_q == S_ABORT);
  assign ERROR     = error_q;
`else
  assign RSP_VALID = (state_q == S_RESP);
  assign ERROR     = 1'b0;
`endif

endmodule
